pipelined_scheduler: RTL and testbench
======================================

PIPELINED_SCHEDULER -- requirements
Module: pipelined_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_QUEUES, default 4, the number of request queues arbitrated (>=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of issued but unretired transactions (power of 2, >=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit in cycles (>=2).
REQ-004 SHALL have port clock, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port selection, input, clog2(NUMBER_OF_QUEUES), the queue chosen by the active policy engine.
REQ-007 SHALL have port valid, input, 1, qualifier for selection.
REQ-008 SHALL have port empty, input, NUMBER_OF_QUEUES, per-queue empty flags.
REQ-009 SHALL have port consumed, input, 1, level signal; each rising edge retires one transaction.
REQ-010 SHALL have port flush, input, 1, synchronous clear of in-flight bookkeeping.
REQ-011 SHALL have port enable, output, 1, one-cycle issue pulse.
REQ-012 SHALL have port id, output, clog2(NUMBER_OF_QUEUES), the queue issued with the latest enable.
REQ-013 SHALL have port update, output, 1, combinational issue strobe for stateful policies (MemGuard, Aging).
REQ-014 SHALL have port hasBeenConsumed, output, NUMBER_OF_QUEUES, one-hot retire strobe.
REQ-015 SHALL have port outstanding, output, clog2(MAX_OUTSTANDING+1), in-flight count.
REQ-016 SHALL have port spurious_consume, output, 1, sticky error flag.
REQ-017 SHALL have port timeout_error, output, 1, sticky error flag.

Function
REQ-018 issue = valid & ~empty[selection] & (outstanding < MAX_OUTSTANDING) & ~flush; update SHALL equal issue in the same cycle.
REQ-019 On issue, the next cycle SHALL have enable=1 and id=selection, and selection SHALL be pushed to an in-order tag FIFO of depth MAX_OUTSTANDING; otherwise enable=0 and id holds.
REQ-020 Issue SHALL be possible on consecutive cycles, including repeatedly to the same queue, while credit remains.
REQ-021 consumed SHALL be registered into consumed_ff; retire_edge = consumed & ~consumed_ff.
REQ-022 On retire_edge with a non-empty FIFO, hasBeenConsumed SHALL combinationally be one-hot at the FIFO head in that cycle, and the head SHALL be popped at the clock edge.
REQ-023 On retire_edge with an empty FIFO, hasBeenConsumed SHALL stay 0, state SHALL be unchanged, and spurious_consume SHALL be set.
REQ-024 On simultaneous issue and retire, push and pop SHALL both occur and outstanding SHALL be unchanged; at full, the retire frees no credit until the next cycle.
REQ-025 outstanding SHALL be +1 on issue only, -1 on retire only (or on watchdog pop), and never wrap.
REQ-026 When flush=1, the next edge SHALL empty the FIFO, zero outstanding and the watchdog, and block issue and retire strobes that cycle; error flags SHALL be kept.
REQ-027 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-028 Reset low SHALL immediately set enable=0, id=0, outstanding=0, FIFO empty, consumed_ff=1, watchdog=0, spurious_consume=0, timeout_error=0.
REQ-029 A level-high consumed at reset release SHALL not count as a retire edge.
REQ-030 Reset asserted mid-transaction SHALL discard all in-flight state with no retire strobes.

Configuration
REQ-031 With macro SCHEDULER_WATCHDOG_EN defined: a counter SHALL increment each cycle while outstanding>0 and no retire occurs, and SHALL clear on retire or when outstanding=0.
REQ-032 With SCHEDULER_WATCHDOG_EN defined: when the counter reaches TIMEOUT_CYCLES, the head SHALL be popped without a hasBeenConsumed strobe, timeout_error SHALL be set, and the counter SHALL clear.
REQ-033 Without SCHEDULER_WATCHDOG_EN, no counter SHALL exist and timeout_error SHALL be tied to 0.

Verification
REQ-034 Reset release, valid=1, selection=2, empty=0 -> enable pulses one cycle later with id=2, update=1 in the issue cycle, outstanding=1.
REQ-035 MAX_OUTSTANDING=4, five back-to-back issues to queues 0,1,2,3,0 -> four enables, fifth blocked, outstanding=4; one consumed edge -> hasBeenConsumed=0001, and queue 0 issues the next cycle.
REQ-036 outstanding=4 with issue and retire in the same cycle -> outstanding stays 4, FIFO order preserved across pointer wrap.
REQ-037 Consumed edge with outstanding=0 -> hasBeenConsumed=0 and spurious_consume=1, which persists through later traffic.
REQ-038 SCHEDULER_WATCHDOG_EN, TIMEOUT_CYCLES=16, one issue and no consumed -> after 16 cycles outstanding=0, timeout_error=1, no hasBeenConsumed strobe.
REQ-039 flush with outstanding=3, then asynchronous reset with outstanding=2 -> each gives outstanding=0 and enable=0; only reset clears the error flags.

Source files
------------

// File: rtl/pipelined_scheduler.sv
// Issue/retire scheduler: tracks in-flight transactions in an in-order tag FIFO and
// raises one-hot retire strobes. Optional watchdog enabled by macro SCHEDULER_WATCHDOG_EN.
module pipelined_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int SEL_W = $clog2(NUMBER_OF_QUEUES),
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SEL_W-1:0]            selection,
    input  logic                        valid,
    input  logic [NUMBER_OF_QUEUES-1:0] empty,
    input  logic                        consumed,
    input  logic                        flush,
    output logic                        enable,
    output logic [SEL_W-1:0]            id,
    output logic                        update,
    output logic [NUMBER_OF_QUEUES-1:0] hasBeenConsumed,
    output logic [OUT_W-1:0]            outstanding,
    output logic                        spurious_consume,
    output logic                        timeout_error
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [MAX_OUTSTANDING-1:0][SEL_W-1:0] tags_q, tags_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic [SEL_W-1:0] id_q, id_d;
    logic             consumed_ff_q, consumed_ff_d;
    logic             spurious_q, spurious_d;
    logic             issue, retire_edge, retire, fifo_empty, timeout_pop, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        fifo_empty    = (cnt_q == '0);
        retire_edge   = consumed & ~consumed_ff_q;
        issue         = valid & ~empty[selection] & (cnt_q < OUT_W'(MAX_OUTSTANDING)) & ~flush;
        retire        = retire_edge & ~fifo_empty & ~flush;
        consumed_ff_d = consumed;
        spurious_d    = spurious_q | (retire_edge & fifo_empty & ~flush);
        enable_d      = issue;
        id_d          = issue ? selection : id_q;
    end

`ifdef SCHEDULER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // The pop fires on the cycle the counter would reach the limit, clearing it.
    always_comb begin
        timeout_pop = ~flush & ~fifo_empty & ~retire & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        wd_d        = (flush | fifo_empty | retire | timeout_pop) ? '0 : wd_q + WD_W'(1);
        timeout_d   = timeout_q | timeout_pop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_error = timeout_q;
`else
    assign timeout_pop   = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        pop      = retire | timeout_pop;
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (issue) begin
            tags_d[wr_ptr_q] = selection;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (issue && !pop)      cnt_d = cnt_q + OUT_W'(1);
        else if (pop && !issue) cnt_d = cnt_q - OUT_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        hasBeenConsumed = '0;
        if (retire) hasBeenConsumed[tags_q[rd_ptr_q]] = 1'b1;
    end

    // consumed_ff resets high so a level already asserted at release is not an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tags_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            id_q          <= '0;
            consumed_ff_q <= 1'b1;
            spurious_q    <= 1'b0;
        end else begin
            tags_q        <= tags_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            id_q          <= id_d;
            consumed_ff_q <= consumed_ff_d;
            spurious_q    <= spurious_d;
        end
    end

    assign update           = issue;
    assign enable           = enable_q;
    assign id               = id_q;
    assign outstanding      = cnt_q;
    assign spurious_consume = spurious_q;
endmodule

// File: tb/tb_pipelined_scheduler.sv
// Directed bench for pipelined_scheduler (4 queues, 4 credits, 16-cycle watchdog).
module tb_pipelined_scheduler;
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] selection;
    logic       valid;
    logic [3:0] empty;
    logic       consumed;
    logic       flush;
    logic       enable;
    logic [1:0] id;
    logic       update;
    logic [3:0] hasBeenConsumed;
    logic [2:0] outstanding;
    logic       spurious_consume;
    logic       timeout_error;

    int checks = 0;
    int failures = 0;

`ifdef SCHEDULER_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    pipelined_scheduler #(.NUMBER_OF_QUEUES(4), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .selection(selection), .valid(valid), .empty(empty),
        .consumed(consumed), .flush(flush), .enable(enable), .id(id), .update(update),
        .hasBeenConsumed(hasBeenConsumed), .outstanding(outstanding),
        .spurious_consume(spurious_consume), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; valid = 1'b0; selection = 2'd0; empty = 4'hF; consumed = 1'b1; flush = 1'b0;
        cyc(); cyc();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%0b exp=0", enable); end
        checks++; if (id !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", id); end
        checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        checks++; if (spurious_consume !== 1'b0 || timeout_error !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=00", spurious_consume, timeout_error); end
        reset = 1'b1;
        cyc(); cyc();
        // consumed held high across release must not register as a retire
        checks++; if (spurious_consume !== 1'b0) begin failures++; $display("FAIL rst_level_consumed got=%0b exp=0", spurious_consume); end
        checks++; if (hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL rst_hbc got=%b exp=0000", hasBeenConsumed); end
        consumed = 1'b0;
        cyc();
    endtask

    task automatic test_single_issue();
        empty = 4'h0; valid = 1'b1; selection = 2'd2;
        #1;
        checks++; if (update !== 1'b1) begin failures++; $display("FAIL single_update got=%0b exp=1", update); end
        cyc();
        valid = 1'b0;
        #1;
        checks++; if (enable !== 1'b1 || id !== 2'd2) begin failures++; $display("FAIL single_enable got=%0b/%0d exp=1/2", enable, id); end
        checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
        checks++; if (update !== 1'b0) begin failures++; $display("FAIL single_update_idle got=%0b exp=0", update); end
        cyc();
        checks++; if (enable !== 1'b0 || id !== 2'd2) begin failures++; $display("FAIL single_pulse got=%0b/%0d exp=0/2", enable, id); end
        consumed = 1'b1;
        #1;
        checks++; if (hasBeenConsumed !== 4'b0100) begin failures++; $display("FAIL single_hbc got=%b exp=0100", hasBeenConsumed); end
        cyc();
        consumed = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0 || hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL single_retired got=%0d/%b exp=0/0000", outstanding, hasBeenConsumed); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            selection = seq[i];
            cyc();
            checks++; if (enable !== 1'b1 || id !== seq[i]) begin failures++; $display("FAIL b2b_issue%0d got=%0b/%0d exp=1/%0d", i, enable, id, seq[i]); end
        end
        selection = 2'd0;
        #1;
        checks++; if (update !== 1'b0) begin failures++; $display("FAIL b2b_full_update got=%0b exp=0", update); end
        cyc();
        checks++; if (enable !== 1'b0 || outstanding !== 3'd4 || id !== 2'd3) begin failures++; $display("FAIL b2b_blocked got=%0b/%0d/%0d exp=0/4/3", enable, outstanding, id); end
        consumed = 1'b1;
        #1;
        checks++; if (hasBeenConsumed !== 4'b0001) begin failures++; $display("FAIL b2b_hbc got=%b exp=0001", hasBeenConsumed); end
        checks++; if (update !== 1'b0) begin failures++; $display("FAIL b2b_no_credit_yet got=%0b exp=0", update); end
        cyc();
        consumed = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3 || update !== 1'b1) begin failures++; $display("FAIL b2b_credit got=%0d/%0b exp=3/1", outstanding, update); end
        cyc();
        valid = 1'b0;
        checks++; if (enable !== 1'b1 || id !== 2'd0 || outstanding !== 3'd4) begin failures++; $display("FAIL b2b_reissue got=%0b/%0d/%0d exp=1/0/4", enable, id, outstanding); end
    endtask

    // FIFO holds 1,2,3,0 with the last entry written after pointer wrap
    task automatic test_wrap();
        logic [1:0] heads [3] = '{2'd3, 2'd0, 2'd3};
        consumed = 1'b1;
        #1;
        checks++; if (hasBeenConsumed !== 4'b0010) begin failures++; $display("FAIL wrap_hbc1 got=%b exp=0010", hasBeenConsumed); end
        cyc();
        consumed = 1'b0;
        cyc();
        consumed = 1'b1; valid = 1'b1; selection = 2'd3;
        #1;
        checks++; if (hasBeenConsumed !== 4'b0100 || update !== 1'b1) begin failures++; $display("FAIL wrap_both got=%b/%0b exp=0100/1", hasBeenConsumed, update); end
        cyc();
        consumed = 1'b0; valid = 1'b0;
        checks++; if (outstanding !== 3'd3 || enable !== 1'b1 || id !== 2'd3) begin failures++; $display("FAIL wrap_unchanged got=%0d/%0b/%0d exp=3/1/3", outstanding, enable, id); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            consumed = 1'b1;
            #1;
            checks++; if (hasBeenConsumed !== 4'(1 << heads[i])) begin failures++; $display("FAIL wrap_order%0d got=%b exp=%b", i, hasBeenConsumed, 4'(1 << heads[i])); end
            cyc();
            consumed = 1'b0;
            cyc();
        end
        checks++; if (outstanding !== 3'd0 || spurious_consume !== 1'b0) begin failures++; $display("FAIL wrap_drained got=%0d/%0b exp=0/0", outstanding, spurious_consume); end
    endtask

    task automatic test_spurious();
        consumed = 1'b1;
        #1;
        checks++; if (hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL spur_hbc got=%b exp=0000", hasBeenConsumed); end
        cyc();
        consumed = 1'b0;
        checks++; if (spurious_consume !== 1'b1 || outstanding !== 3'd0) begin failures++; $display("FAIL spur_flag got=%0b/%0d exp=1/0", spurious_consume, outstanding); end
        valid = 1'b1; selection = 2'd1;
        cyc();
        valid = 1'b0; consumed = 1'b1;
        #1;
        checks++; if (hasBeenConsumed !== 4'b0010) begin failures++; $display("FAIL spur_traffic_hbc got=%b exp=0010", hasBeenConsumed); end
        cyc();
        consumed = 1'b0;
        checks++; if (spurious_consume !== 1'b1 || outstanding !== 3'd0) begin failures++; $display("FAIL spur_sticky got=%0b/%0d exp=1/0", spurious_consume, outstanding); end
        cyc();
    endtask

    task automatic test_watchdog();
        int bad = 0;
        valid = 1'b1; selection = 2'd2;
        cyc();
        valid = 1'b0;
        checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL wd_issue got=%0d exp=1", outstanding); end
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (outstanding !== 3'd1 || hasBeenConsumed !== 4'h0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL wd_hold got=%0d bad cycles exp=0", bad); end
        cyc();
        checks++; if (outstanding !== (WD_ON ? 3'd0 : 3'd1)) begin failures++; $display("FAIL wd_pop got=%0d exp=%0d", outstanding, WD_ON ? 0 : 1); end
        checks++; if (timeout_error !== WD_ON || hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL wd_flag got=%0b/%b exp=%0b/0000", timeout_error, hasBeenConsumed, WD_ON); end
        if (!WD_ON) begin
            consumed = 1'b1;
            cyc();
            consumed = 1'b0;
            cyc();
        end
        cyc();
    endtask

    task automatic test_flush_reset();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            selection = 2'(i);
            cyc();
        end
        checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL fl_fill got=%0d exp=3", outstanding); end
        flush = 1'b1; selection = 2'd3; consumed = 1'b1;
        #1;
        checks++; if (update !== 1'b0 || hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL fl_block got=%0b/%b exp=0/0000", update, hasBeenConsumed); end
        cyc();
        flush = 1'b0; valid = 1'b0; consumed = 1'b0;
        checks++; if (outstanding !== 3'd0 || enable !== 1'b0) begin failures++; $display("FAIL fl_clear got=%0d/%0b exp=0/0", outstanding, enable); end
        checks++; if (spurious_consume !== 1'b1 || timeout_error !== WD_ON) begin failures++; $display("FAIL fl_flags_kept got=%0b/%0b exp=1/%0b", spurious_consume, timeout_error, WD_ON); end
        valid = 1'b1; selection = 2'd1;
        cyc();
        selection = 2'd2;
        cyc();
        valid = 1'b0;
        checks++; if (outstanding !== 3'd2 || enable !== 1'b1 || id !== 2'd2) begin failures++; $display("FAIL fl_refill got=%0d/%0b/%0d exp=2/1/2", outstanding, enable, id); end
        #2 reset = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0 || enable !== 1'b0 || id !== 2'd0) begin failures++; $display("FAIL rst_async got=%0d/%0b/%0d exp=0/0/0", outstanding, enable, id); end
        checks++; if (spurious_consume !== 1'b0 || timeout_error !== 1'b0 || hasBeenConsumed !== 4'h0) begin failures++; $display("FAIL rst_async_flags got=%0b/%0b/%b exp=0/0/0000", spurious_consume, timeout_error, hasBeenConsumed); end
        #3 reset = 1'b1;
        cyc(); cyc();
        checks++; if (outstanding !== 3'd0 || enable !== 1'b0) begin failures++; $display("FAIL rst_after got=%0d/%0b exp=0/0", outstanding, enable); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_wrap();
        test_spurious();
        test_watchdog();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_sim got=running exp=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
